// File: rtl/iteration_end_barrier.sv
// Per-core iteration-end barrier with a registered vertex pass-through.
// Optional barrier watchdog enabled by defining ITER_END_TIMEOUT_EN.
module iteration_end_barrier #(
    parameter int V_ID_WIDTH     = 16,
    parameter int CORE_NUM       = 4,
    parameter int ITER_WIDTH     = 16,
    parameter int MAX_ITER       = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CORE_NUM*V_ID_WIDTH-1:0] front_active_v_id,
    input  logic [CORE_NUM-1:0]            front_active_v_updated,
    input  logic [CORE_NUM-1:0]            front_active_v_pull_first_flag,
    input  logic [CORE_NUM-1:0]            front_active_v_valid,
    input  logic [CORE_NUM-1:0]            front_iteration_end,
    input  logic [CORE_NUM-1:0]            front_iteration_end_valid,
    output logic [CORE_NUM*V_ID_WIDTH-1:0] active_v_id,
    output logic [CORE_NUM-1:0]            active_v_updated,
    output logic [CORE_NUM-1:0]            active_v_pull_first_flag,
    output logic [CORE_NUM-1:0]            active_v_valid,
    output logic [CORE_NUM-1:0]            iteration_end,
    output logic [CORE_NUM-1:0]            iteration_end_valid,
    output logic [ITER_WIDTH-1:0]          iteration_cnt,
    output logic                           global_done,
    output logic                           protocol_err,
    output logic                           barrier_timeout
);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam logic [ITER_WIDTH:0] LP_MAX = (ITER_WIDTH+1)'(MAX_ITER);

    state_t                         r_state;
    state_t                         w_state_n;
    logic [CORE_NUM-1:0]            r_arrived;
    logic [CORE_NUM-1:0]            w_arrived_n;
    logic [CORE_NUM-1:0]            r_end_acc;
    logic [CORE_NUM-1:0]            w_end_acc_n;
    logic [ITER_WIDTH-1:0]          r_cnt;
    logic [ITER_WIDTH-1:0]          w_cnt_n;
    logic [CORE_NUM-1:0]            r_iev;
    logic [CORE_NUM-1:0]            w_iev_n;
    logic [CORE_NUM-1:0]            r_ie;
    logic [CORE_NUM-1:0]            w_ie_n;
    logic                           r_done;
    logic                           w_done_n;
    logic                           r_perr;
    logic                           w_perr_n;

    logic [CORE_NUM*V_ID_WIDTH-1:0] r_vid;
    logic [CORE_NUM-1:0]            r_vupd;
    logic [CORE_NUM-1:0]            r_vpf;
    logic [CORE_NUM-1:0]            r_vvld;

    logic [CORE_NUM-1:0]            w_new;
    logic [CORE_NUM-1:0]            w_dup;
    logic [CORE_NUM-1:0]            w_arr_acc;
    logic [CORE_NUM-1:0]            w_acc_acc;
    logic [ITER_WIDTH:0]            w_cnt_inc;
    logic [ITER_WIDTH-1:0]          w_cnt_sat;
    logic                           w_max_hit;
    logic                           w_end_hit;
    logic                           w_all_in;

    // First token of an iteration wins; repeats are flagged, not merged.
    assign w_new     = front_iteration_end_valid & ~r_arrived;
    assign w_dup     = front_iteration_end_valid & r_arrived;
    assign w_arr_acc = r_arrived | front_iteration_end_valid;
    assign w_acc_acc = (r_end_acc & ~w_new) | (front_iteration_end & w_new);
    assign w_all_in  = &w_arr_acc;

    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
    assign w_cnt_sat = (&r_cnt) ? r_cnt : w_cnt_inc[ITER_WIDTH-1:0];
    assign w_max_hit = (MAX_ITER != 0) && (w_cnt_inc == LP_MAX);
    assign w_end_hit = (&w_acc_acc) || w_max_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_COLLECT;
            r_arrived <= '0;
            r_end_acc <= '0;
            r_cnt     <= '0;
            r_iev     <= '0;
            r_ie      <= '0;
            r_done    <= 1'b0;
            r_perr    <= 1'b0;
            r_vid     <= '0;
            r_vupd    <= '0;
            r_vpf     <= '0;
            r_vvld    <= '0;
        end else begin
            r_state   <= w_state_n;
            r_arrived <= w_arrived_n;
            r_end_acc <= w_end_acc_n;
            r_cnt     <= w_cnt_n;
            r_iev     <= w_iev_n;
            r_ie      <= w_ie_n;
            r_done    <= w_done_n;
            r_perr    <= w_perr_n;
            r_vid     <= front_active_v_id;
            r_vupd    <= front_active_v_updated;
            r_vpf     <= front_active_v_pull_first_flag;
            r_vvld    <= front_active_v_valid;
        end
    end

    // Release outputs are registered on the edge that sees the last token.
    always_comb begin
        w_state_n   = r_state;
        w_arrived_n = r_arrived;
        w_end_acc_n = r_end_acc;
        w_cnt_n     = r_cnt;
        w_iev_n     = '0;
        w_ie_n      = r_ie;
        w_done_n    = r_done;
        w_perr_n    = r_perr;
        unique case (r_state)
            S_COLLECT: begin
                w_arrived_n = w_arr_acc;
                w_end_acc_n = w_acc_acc;
                if (|w_dup) begin
                    w_perr_n = 1'b1;
                end
                if (w_all_in) begin
                    w_state_n   = S_RELEASE;
                    w_arrived_n = '0;
                    w_iev_n     = '1;
                    w_ie_n      = {CORE_NUM{w_end_hit}};
                    w_cnt_n     = w_cnt_sat;
                    w_done_n    = w_end_hit;
                end
            end
            S_RELEASE: begin
                if (r_done) begin
                    w_state_n = S_DONE;
                end else begin
                    w_state_n   = S_COLLECT;
                    w_ie_n      = '0;
                    w_arrived_n = w_arr_acc;
                    w_end_acc_n = w_acc_acc;
                end
            end
            S_DONE: begin
                w_state_n = S_DONE;
            end
            default: begin
                w_state_n = S_COLLECT;
            end
        endcase
    end

`ifdef ITER_END_TIMEOUT_EN
    localparam int LP_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LP_TW-1:0] LP_TO = LP_TW'(TIMEOUT_CYCLES);

    logic [LP_TW-1:0] r_wait;
    logic             r_timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_COLLECT && w_all_in) begin
                r_wait <= '0;
            end else if (r_state == S_COLLECT && (|r_arrived) && r_wait != LP_TO) begin
                r_wait <= r_wait + 1'b1;
            end
            if (r_wait == LP_TO) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign barrier_timeout = r_timeout;
`else
    assign barrier_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    assign active_v_id              = r_vid;
    assign active_v_updated         = r_vupd;
    assign active_v_pull_first_flag = r_vpf;
    assign active_v_valid           = r_vvld & {CORE_NUM{r_state != S_DONE}};
    assign iteration_end            = r_ie;
    assign iteration_end_valid      = r_iev;
    assign iteration_cnt            = r_cnt;
    assign global_done              = r_done;
    assign protocol_err             = r_perr;

endmodule

// File: tb/tb_iteration_end_barrier.sv
// Bench for iteration_end_barrier: directed literal checks plus
// randomized tokens compared every cycle against an iteration-level model.
module tb_iteration_end_barrier;

    localparam int CN   = 4;
    localparam int VW   = 8;
    localparam int IW   = 8;
    localparam int MAXI = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CN*VW-1:0]  f_id;
    logic [CN-1:0]     f_upd, f_pf, f_vld, f_ie, f_iev;
    logic [CN*VW-1:0]  o_id;
    logic [CN-1:0]     o_upd, o_pf, o_vld, o_ie, o_iev;
    logic [IW-1:0]     o_cnt;
    logic              o_done, o_perr, o_to;

    always #5 clk = ~clk;

    iteration_end_barrier #(
        .V_ID_WIDTH(VW), .CORE_NUM(CN), .ITER_WIDTH(IW),
        .MAX_ITER(MAXI), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .front_active_v_id(f_id),
        .front_active_v_updated(f_upd),
        .front_active_v_pull_first_flag(f_pf),
        .front_active_v_valid(f_vld),
        .front_iteration_end(f_ie),
        .front_iteration_end_valid(f_iev),
        .active_v_id(o_id),
        .active_v_updated(o_upd),
        .active_v_pull_first_flag(o_pf),
        .active_v_valid(o_vld),
        .iteration_end(o_ie),
        .iteration_end_valid(o_iev),
        .iteration_cnt(o_cnt),
        .global_done(o_done),
        .protocol_err(o_perr),
        .barrier_timeout(o_to)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Iteration-level model: which cores have reported, what they said,
    // whether a release pulse is showing, and the run status.
    typedef struct packed {
        logic [CN-1:0]    arr;
        logic [CN-1:0]    acc;
        logic             pulse;
        logic             done;
        logic             perr;
        logic [IW-1:0]    cnt;
        logic [CN*VW-1:0] id;
        logic [CN-1:0]    upd;
        logic [CN-1:0]    pf;
        logic [CN-1:0]    vld;
    } model_t;

    model_t m    = '0;
    bit     m_ok = 1'b0;

    function automatic model_t m_next(model_t s);
        model_t n;
        bit     was_pulse;
        n = s;
        if (!rst_n) begin
            n = '0;
            return n;
        end
        n.id  = f_id;
        n.upd = f_upd;
        n.pf  = f_pf;
        n.vld = f_vld;
        was_pulse = s.pulse;
        n.pulse = 1'b0;
        if (!s.done) begin
            for (int i = 0; i < CN; i++) begin
                if (f_iev[i]) begin
                    if (s.arr[i]) begin
                        n.perr = 1'b1;
                    end else begin
                        n.arr[i] = 1'b1;
                        n.acc[i] = f_ie[i];
                    end
                end
            end
            if (!was_pulse && n.arr == '1) begin
                n.pulse = 1'b1;
                n.arr   = '0;
                if (n.cnt != '1) n.cnt = n.cnt + 1'b1;
                if (n.acc == '1 || int'(n.cnt) == MAXI) n.done = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m    <= m_next(m);
        m_ok <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("active_v_id", o_id, m.id);
            chk("active_v_updated", o_upd, m.upd);
            chk("active_v_pull_first", o_pf, m.pf);
            chk("active_v_valid", o_vld, (m.done && !m.pulse) ? '0 : m.vld);
            chk("iteration_end_valid", o_iev, m.pulse ? {CN{1'b1}} : '0);
            chk("iteration_end", o_ie, m.done ? {CN{1'b1}} : '0);
            chk("iteration_cnt", o_cnt, m.cnt);
            chk("global_done", o_done, m.done);
            chk("protocol_err", o_perr, m.perr);
            chk("barrier_timeout", o_to, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_id  = '0;
        f_upd = '0;
        f_pf  = '0;
        f_vld = '0;
        f_ie  = '0;
        f_iev = '0;
    endtask

    task automatic tok(input logic [CN-1:0] v, input logic [CN-1:0] e);
        f_iev = v;
        f_ie  = e;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        idle();
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (10) tick();
        chk("reset cnt", o_cnt, 0);
        chk("reset iev", o_iev, 0);
        chk("reset ie", o_ie, 0);
        chk("reset done", o_done, 0);
        chk("reset vvalid", o_vld, 0);
        chk("reset perr", o_perr, 0);
        rst_n = 1'b1;

        f_id  = {8'd3, 8'd2, 8'd1, 8'd0};
        f_upd = 4'hf;
        f_pf  = 4'hf;
        f_vld = 4'hf;
        tick();
        chk("fwd id", o_id, 32'h03020100);
        chk("fwd valid", o_vld, 4'hf);
        chk("fwd updated", o_upd, 4'hf);
        chk("fwd pull_first", o_pf, 4'hf);
        idle();

        tok(4'h1, 4'h1);
        tick();
        tok(4'h0, 4'h0);
        tick();
        tick();
        tok(4'he, 4'h0);
        tick();
        chk("staggered iev", o_iev, 4'hf);
        chk("staggered ie", o_ie, 4'h0);
        chk("staggered cnt", o_cnt, 1);
        tok(4'h0, 4'h0);
        tick();
        chk("staggered iev low", o_iev, 4'h0);

        tok(4'h1, 4'h1);
        tick();
        tok(4'h1, 4'h0);
        tick();
        chk("dup perr", o_perr, 1);
        chk("dup no release", o_iev, 4'h0);
        tok(4'he, 4'he);
        tick();
        chk("dup release iev", o_iev, 4'hf);
        chk("dup first end kept", o_ie, 4'hf);
        chk("dup cnt", o_cnt, 2);
        chk("dup done", o_done, 1);
        tok(4'h0, 4'h0);
        tick();

        do_reset(2);
        chk("reset clears perr", o_perr, 0);
        f_vld = 4'hf;
        tok(4'hf, 4'hf);
        tick();
        chk("all end iev", o_iev, 4'hf);
        chk("all end ie", o_ie, 4'hf);
        chk("all end done", o_done, 1);
        chk("all end cnt", o_cnt, 1);
        tok(4'hf, 4'h0);
        tick();
        chk("done iev", o_iev, 4'h0);
        chk("done ie held", o_ie, 4'hf);
        chk("done vvalid", o_vld, 4'h0);
        chk("done no perr", o_perr, 0);
        tick();
        chk("done cnt frozen", o_cnt, 1);

        do_reset(2);
        for (int k = 1; k <= 3; k++) begin
            tok(4'hf, 4'h0);
            tick();
            chk("maxiter iev", o_iev, 4'hf);
            chk("maxiter cnt", o_cnt, k);
            chk("maxiter ie", o_ie, (k == 3) ? 4'hf : 4'h0);
            chk("maxiter done", o_done, (k == 3) ? 1 : 0);
            tok(4'h0, 4'h0);
            tick();
        end
        chk("maxiter final done", o_done, 1);

        for (int ep = 0; ep < 8; ep++) begin
            do_reset(2);
            for (int c = 0; c < 300; c++) begin
                rst_n = ($urandom_range(0, 59) != 0);
                f_id  = $urandom;
                f_upd = 4'($urandom);
                f_pf  = 4'($urandom);
                f_vld = 4'($urandom);
                for (int i = 0; i < CN; i++) begin
                    f_iev[i] = ($urandom_range(0, 2) == 0);
                    if (ep % 2 == 0) f_ie[i] = ($urandom_range(0, 7) == 0);
                    else f_ie[i] = ($urandom_range(0, 3) != 0);
                end
                tick();
            end
        end

        rst_n = 1'b1;
        idle();
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
